// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store sequencer; word-aligned bus beats with strobes, splits word-crossing accesses.
// Latency: accept->resp 2 cycles single-beat, 3 cycles two-beat (+1 per ack wait cycle), 1 cycle for illegal size.
// Backpressure: req_ready only in IDLE; bus waits on bus_ack with outputs held; no backpressure on resp.
module mem_access_unit #(
    parameter int REG_WIDTH_IN_BYTE = 4,
    parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [2:0]                    req_funct3,
    input  logic [31:0]                   req_addr,
    input  logic [REG_WIDTH_IN_BIT-1:0]   req_wdata,
    output logic                          resp_valid,
    output logic [REG_WIDTH_IN_BIT-1:0]   resp_rdata,
    output logic [2:0]                    resp_funct3,
    output logic                          resp_error,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [31:0]                   bus_addr,
    output logic [REG_WIDTH_IN_BYTE-1:0]  bus_wstrb,
    output logic [REG_WIDTH_IN_BIT-1:0]   bus_wdata,
    input  logic                          bus_ack,
    input  logic [REG_WIDTH_IN_BIT-1:0]   bus_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [29:0] word_addr_q;
    logic [1:0]  off_q;
    logic [7:0]  smask_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [7:0]  req_mask;
    logic [7:0]  req_smask;
    logic        req_illegal;
    logic        accept;
    logic        two_beat;
    logic [4:0]  sh0;
    logic [2:0]  inv_off;
    logic [5:0]  sh1;
    logic [31:0] size_mask;
    logic [31:0] beat0_data;
    logic [31:0] beat1_data;

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign accept      = req_valid && req_ready;
    assign req_illegal = (req_funct3[1:0] == 2'b11);

    // Byte mask of the incoming request, shifted into an 8-byte window spanning two words.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_mask = 8'h01;
            2'b01:   req_mask = 8'h03;
            2'b10:   req_mask = 8'h0F;
            default: req_mask = 8'h00;
        endcase
        req_smask = req_mask << req_addr[1:0];
    end

    // Lane shift amounts and size mask for the registered request; beat1 only exists when off != 0.
    always_comb begin
        two_beat = |smask_q[7:4];
        sh0      = {off_q, 3'b000};
        inv_off  = 3'd4 - {1'b0, off_q};
        sh1      = {inv_off, 3'b000};
        case (funct3_q[1:0])
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            2'b10:   size_mask = 32'hFFFF_FFFF;
            default: size_mask = 32'h0000_0000;
        endcase
        beat0_data = bus_rdata >> sh0;
        beat1_data = rdata_q | (bus_rdata << sh1);
    end

    // Bus outputs decode purely from state and captured fields, so reset drops them at once.
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wstrb = '0;
        bus_wdata = '0;
        if (state_q == S_BEAT0) begin
            bus_req   = 1'b1;
            bus_we    = write_q;
            bus_addr  = {word_addr_q, 2'b00};
            bus_wstrb = smask_q[3:0];
            bus_wdata = wdata_q << sh0;
        end else if (state_q == S_BEAT1) begin
            bus_req   = 1'b1;
            bus_we    = write_q;
            bus_addr  = {word_addr_q + 30'd1, 2'b00};
            bus_wstrb = smask_q[7:4];
            bus_wdata = wdata_q >> sh1;
        end
    end

    // Capture all request fields at accept; later req_* activity is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            word_addr_q <= '0;
            off_q       <= 2'b00;
            smask_q     <= 8'h00;
            wdata_q     <= '0;
        end else if (accept) begin
            write_q     <= req_write;
            funct3_q    <= req_funct3;
            word_addr_q <= req_addr[31:2];
            off_q       <= req_addr[1:0];
            smask_q     <= req_smask;
            wdata_q     <= req_wdata;
        end
    end

    // Sequencer: IDLE -> BEAT0 [-> BEAT1] -> RESP, with illegal sizes skipping the bus entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= req_illegal ? S_RESP : S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (bus_ack) begin
                        rdata_q <= beat0_data;
                        state_q <= two_beat ? S_BEAT1 : S_RESP;
                    end
                end
                S_BEAT1: begin
                    if (bus_ack) begin
                        state_q <= S_RESP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Response fields update only on entry to RESP and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata  <= '0;
            resp_funct3 <= 3'b000;
            resp_error  <= 1'b0;
        end else if (state_q == S_IDLE && accept && req_illegal) begin
            resp_rdata  <= '0;
            resp_funct3 <= req_funct3;
            resp_error  <= 1'b1;
        end else if (state_q == S_BEAT0 && bus_ack && !two_beat) begin
            resp_rdata  <= write_q ? '0 : (beat0_data & size_mask);
            resp_funct3 <= funct3_q;
            resp_error  <= 1'b0;
        end else if (state_q == S_BEAT1 && bus_ack) begin
            resp_rdata  <= write_q ? '0 : (beat1_data & size_mask);
            resp_funct3 <= funct3_q;
            resp_error  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_funct3;
    logic        resp_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.REG_WIDTH_IN_BYTE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_funct3(resp_funct3),
        .resp_error (resp_error),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (strb[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Wait (bounded) for req_ready, present the request, and return right after the accept edge.
    task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, "ready_before_accept", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
    endtask

    // One request end to end: byte-level model of which lanes of which word each request byte maps to.
    task automatic run_txn(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int d0, input int d1,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        logic [31:0] e_addr [2];
        logic [3:0]  e_strb [2];
        logic [31:0] e_wd   [2];
        logic [31:0] rd     [2];
        int          dl     [2];
        logic [31:0] e_rdata;
        logic        illegal;
        int          sz, off, nbeats, lat, beat, waited, cyc;
        bit          done;

        rd[0] = rd0; rd[1] = rd1;
        dl[0] = d0;  dl[1] = d1;
        e_strb[0] = '0; e_strb[1] = '0;
        e_wd[0] = '0;   e_wd[1] = '0;
        e_rdata = '0;
        nbeats  = 0;
        illegal = (f3[1:0] == 2'b11);
        sz      = 1 << f3[1:0];
        off     = int'(addr[1:0]);
        e_addr[0] = {addr[31:2], 2'b00};
        e_addr[1] = e_addr[0] + 32'd4;
        if (!illegal) begin
            for (int i = 0; i < sz; i++) begin
                int pos;
                int b;
                int ln;
                pos = off + i;
                b   = pos / 4;
                ln  = pos % 4;
                e_strb[b][ln] = 1'b1;
                e_wd[b][ln*8 +: 8] = wd[i*8 +: 8];
                if (!wr) e_rdata[i*8 +: 8] = rd[b][ln*8 +: 8];
                if (b + 1 > nbeats) nbeats = b + 1;
            end
        end
        lat = illegal ? 1 : 1 + (d0 + 1) + ((nbeats == 2) ? d1 + 1 : 0);

        issue(tag, wr, f3, addr, wd);

        beat = 0; waited = 0; cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid  = 1'b0;
                req_write  = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (bus_req) begin
                if (illegal || beat >= nbeats) begin
                    chk(tag, "unexpected_bus_req", bus_req, 0);
                end else begin
                    chk(tag, $sformatf("beat%0d_addr", beat), bus_addr, e_addr[beat]);
                    chk(tag, $sformatf("beat%0d_wstrb", beat), bus_wstrb, e_strb[beat]);
                    chk(tag, $sformatf("beat%0d_we", beat), bus_we, wr);
                    if (wr) chk(tag, $sformatf("beat%0d_wdata", beat),
                                bus_wdata & lane_mask(e_strb[beat]), e_wd[beat]);
                    if (waited == dl[beat]) begin
                        bus_ack   = 1'b1;
                        bus_rdata = rd[beat];
                        beat++;
                        waited = 0;
                    end else begin
                        waited++;
                    end
                end
            end else begin
                bus_ack = 1'($urandom_range(0, 1));
            end
            if (resp_valid) begin
                chk(tag, "resp_cycle", cyc, lat);
                chk(tag, "beats_used", beat, nbeats);
                chk(tag, "resp_rdata", resp_rdata, e_rdata);
                chk(tag, "resp_funct3", resp_funct3, f3);
                chk(tag, "resp_error", resp_error, illegal);
                done = 1;
            end else begin
                chk(tag, "req_ready_busy", req_ready, 0);
            end
        end
        if (!done) chk(tag, "timeout_resp_valid", resp_valid, 1);
        @(negedge clk);
        bus_ack = 1'b0;
        chk(tag, "resp_single_pulse", resp_valid, 0);
        chk(tag, "ready_after_resp", req_ready, 1);
        chk(tag, "resp_rdata_hold", resp_rdata, e_rdata);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;

        repeat (3) @(negedge clk);
        chk("reset", "req_ready", req_ready, 1);
        chk("reset", "resp_valid", resp_valid, 0);
        chk("reset", "resp_rdata", resp_rdata, 0);
        chk("reset", "resp_funct3", resp_funct3, 0);
        chk("reset", "resp_error", resp_error, 0);
        chk("reset", "bus_req", bus_req, 0);
        chk("reset", "bus_we", bus_we, 0);
        chk("reset", "bus_addr", bus_addr, 0);
        chk("reset", "bus_wstrb", bus_wstrb, 0);
        chk("reset", "bus_wdata", bus_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", "req_ready", req_ready, 1);
        chk("post_reset", "bus_req", bus_req, 0);

        // Directed cases
        run_txn("lw_aligned",  1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'h0);
        run_txn("lb_off3",     1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80AA_BBCC, 32'h0);
        run_txn("sh_split",    1'b1, 3'b001, 32'h0000_0203, 32'h0000_1234, 0, 0, 32'h0, 32'h0);
        run_txn("lw_split_wait", 1'b0, 3'b010, 32'h0000_0302, 32'h0, 2, 2, 32'h5566_1111, 32'h2222_7788);
        run_txn("illegal_f3",  1'b0, 3'b011, 32'h0000_0400, 32'h0, 0, 0, 32'h0, 32'h0);
        run_txn("lhu_wrap",    1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 1, 0, 32'hA1B2_C3D4, 32'h1122_3344);
        run_txn("sw_off1",     1'b1, 3'b010, 32'h0000_0501, 32'hCAFE_F00D, 0, 1, 32'h0, 32'h0);
        run_txn("sb_off0",     1'b1, 3'b000, 32'h0000_0600, 32'hFFFF_FF5A, 0, 0, 32'h0, 32'h0);
        run_txn("illegal_st",  1'b1, 3'b111, 32'h0000_0702, 32'h1234_5678, 0, 0, 32'h0, 32'h0);

        // Reset during BEAT1 of a two-beat store
        issue("rst_mid", 1'b1, 3'b001, 32'h0000_0803, 32'h0000_ABCD);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid", "beat0_bus_req", bus_req, 1);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rst_mid", "beat1_bus_req", bus_req, 1);
        chk("rst_mid", "beat1_addr", bus_addr, 32'h0000_0804);
        rst = 1'b1;
        #1;
        chk("rst_mid", "bus_req_async_drop", bus_req, 0);
        chk("rst_mid", "resp_valid", resp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid", "held_resp_valid", resp_valid, 0);
            chk("rst_mid", "held_bus_req", bus_req, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mid", "after_resp_valid", resp_valid, 0);
            chk("rst_mid", "after_req_ready", req_ready, 1);
        end
        run_txn("lw_after_rst", 1'b0, 3'b010, 32'h0000_0900, 32'h0, 0, 0, 32'h0BAD_F00D, 32'h0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            run_txn($sformatf("rand%0d", t), 1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
